// File: rtl/past_history_pkg.sv
// Shared helpers for the past_history block: clog2 sizing.
package past_history_pkg;

  function automatic int ph_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // sel/fill must hold the value DEPTH itself, hence DEPTH+1.
  function automatic int ph_sel_w(input int depth);
    return ph_clog2(depth + 1);
  endfunction

endpackage

// File: rtl/past_shift_reg.sv
// History shift chain with a saturating fill counter; advances only on enabled edges.
module past_shift_reg
  import past_history_pkg::*;
#(
  parameter int                 WIDTH     = 1,
  parameter int                 DEPTH     = 4,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  parameter int                 SEL_W     = ph_sel_w(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [WIDTH-1:0]             d,
  output logic [DEPTH-1:0][WIDTH-1:0]  hist,
  output logic [SEL_W-1:0]             fill
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= {DEPTH{RESET_VAL}};
      fill <= '0;
    end else if (en) begin
      hist[0] <= d;
      for (int i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
      if (fill != SEL_W'(DEPTH)) fill <= fill + 1'b1;
    end
  end

endmodule

// File: rtl/past_history.sv
// Parametrised $past/$rose/$fell/$stable/$changed history with validity tracking.
module past_history
  import past_history_pkg::*;
#(
  parameter int                 WIDTH     = 1,
  parameter int                 DEPTH     = 4,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  parameter int                 SEL_W     = ph_sel_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [WIDTH-1:0]  d,
  input  logic [SEL_W-1:0]  sel,
  output logic [WIDTH-1:0]  past_q,
  output logic              past_valid,
  output logic              sel_err,
  output logic [SEL_W-1:0]  fill,
  output logic [WIDTH-1:0]  rose,
  output logic [WIDTH-1:0]  fell,
  output logic [WIDTH-1:0]  changed,
  output logic [WIDTH-1:0]  stable
);

  logic [DEPTH-1:0][WIDTH-1:0] hist;
  logic                        cmp_valid;

  past_shift_reg #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .RESET_VAL (RESET_VAL),
    .SEL_W     (SEL_W)
  ) u_shift (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .d    (d),
    .hist (hist),
    .fill (fill)
  );

  assign sel_err    = (sel == '0) || (sel > SEL_W'(DEPTH));
  assign past_valid = !sel_err && (fill >= sel);
  assign cmp_valid  = fill >= SEL_W'(2);

  // Compare-based mux: an illegal sel never reaches an array index.
  always_comb begin
    past_q = '0;
    if (!sel_err) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (sel == SEL_W'(i + 1)) past_q = hist[i];
      end
    end
  end

  always_comb begin
    rose    = '0;
    fell    = '0;
    changed = '0;
    stable  = '0;
    if (cmp_valid) begin
      rose    = ~hist[1] &  hist[0];
      fell    =  hist[1] & ~hist[0];
      changed =  hist[1] ^  hist[0];
      stable  = ~(hist[1] ^ hist[0]);
    end
  end

`ifdef FORMAL
`ifndef PAST_HISTORY_NO_ASSERT
  for (genvar k = 1; k <= DEPTH; k++) begin : g_past_eq
    a_past_eq: assert property (@(posedge clk) disable iff (rst)
      (en && past_valid && sel == SEL_W'(k)) |-> (past_q == $past(d, k, en)));
  end

  a_fill_max: assert property (@(posedge clk) fill <= SEL_W'(DEPTH));

  a_fill_mono: assert property (@(posedge clk) disable iff (rst)
    !$past(rst) |-> (fill >= $past(fill)));
`endif
`endif

endmodule
